// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared types and constants for the SOPC two-master memory arbiter.
package sopc_mem_arbiter_pkg;

  // Arbiter FSM state encodings.
  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbGnt0 = 2'd1,
    ArbGnt1 = 2'd2,
    ArbResp = 2'd3
  } arb_state_e;

  // Reset is asserted when rst equals this level.
  localparam logic RstnEnable = 1'b0;

  // Width of the per-access wait counter (MAX_WAIT up to 255).
  localparam int WaitCntW = 8;

endpackage

// File: rtl/sopc_arb_rr.sv
// 2-way round-robin picker: on a tie, the master not granted last wins.
module sopc_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_idx,
  output logic gnt_vld
);

  // Pick a master; a lone request wins outright, a tie goes to ~last_gnt.
  always_comb begin
    gnt_vld = req0 | req1;
    if (req0 && req1) gnt_idx = ~last_gnt;
    else              gnt_idx = req1;
  end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Serialises fetch (m0) and load/store (m1) accesses onto the single slave
// port with round-robin fairness and a per-access timeout.
module sopc_mem_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,
  output logic                m1_err,
  output logic                s_ce,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ack,
  output logic                stallreq
);

  localparam logic [WaitCntW-1:0] TimeoutCnt = WaitCntW'(MAX_WAIT - 1);

  arb_state_e          state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;
  logic                gnt_idx, gnt_vld;
  logic                gnt_m;

  sopc_arb_rr u_rr (
    .req0     (m0_req),
    .req1     (m1_req),
    .last_gnt (last_gnt_q),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  // Index of the master currently holding the slave (valid in GNT states).
  assign gnt_m = (state_q == ArbGnt1);

  // State register; reset mid-access drops straight back to IDLE with no ack.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      state_q    <= ArbIdle;
      last_gnt_q <= 1'b1;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for ack or timeout in GNT, one RESP cycle.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    case (state_q)
      ArbIdle: begin
        wait_cnt_d = '0;
        if (gnt_vld) state_d = gnt_idx ? ArbGnt1 : ArbGnt0;
      end
      ArbGnt0, ArbGnt1: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A slave ack in the timeout cycle still counts as a good access.
        if (s_ack) begin
          if (gnt_m) rd1_d = s_rdata;
          else       rd0_d = s_rdata;
          err_d      = 1'b0;
          last_gnt_d = gnt_m;
          wait_cnt_d = '0;
          state_d    = ArbResp;
        end else if (wait_cnt_q == TimeoutCnt) begin
          if (gnt_m) rd1_d = '0;
          else       rd0_d = '0;
          err_d      = 1'b1;
          last_gnt_d = gnt_m;
          wait_cnt_d = '0;
          state_d    = ArbResp;
        end
      end
      ArbResp: state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  // Slave port mux; m0 is read-only so its write fields are tied off.
  always_comb begin
    s_ce    = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_sel   = '0;
    case (state_q)
      ArbGnt0: begin
        s_ce   = 1'b1;
        s_addr = m0_addr;
        s_sel  = '1;
      end
      ArbGnt1: begin
        s_ce    = 1'b1;
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_sel   = m1_sel;
      end
      default: ;
    endcase
  end

  // RESP belongs to whichever master completed last, recorded in last_gnt.
  assign m0_ack   = (state_q == ArbResp) && !last_gnt_q;
  assign m1_ack   = (state_q == ArbResp) &&  last_gnt_q;
  assign m0_err   = m0_ack & err_q;
  assign m1_err   = m1_ack & err_q;
  assign m0_rdata = rd0_q;
  assign m1_rdata = rd1_q;

  assign stallreq = (rst != RstnEnable) &
                    ((m0_req & ~m0_ack) | (m1_req & ~m1_ack));

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter: a cycle-by-cycle vector table plus
// hand-written timeout, ack/timeout collision and mid-access reset sequences.
module tb_sopc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m1_we, s_ack;
  logic [31:0] m0_addr, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m1_sel;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_ce, s_we, stallreq;
  logic [3:0]  s_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sopc_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_sel(m1_sel), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_ce(s_ce), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_sel(s_sel), .s_rdata(s_rdata), .s_ack(s_ack), .stallreq(stallreq)
  );

  typedef struct {
    logic m0r; logic [31:0] m0a;
    logic m1r; logic m1we; logic [31:0] m1a; logic [31:0] m1wd; logic [3:0] m1sel;
    logic sack; logic [31:0] srd;
    logic ce; logic we; logic [31:0] addr; logic [31:0] wd; logic [3:0] sel;
    logic a0; logic e0; logic [31:0] rd0;
    logic a1; logic e1; logic [31:0] rd1;
    logic stall;
  } vec_t;

  function automatic vec_t vi(logic m0r, logic [31:0] m0a, logic m1r, logic m1we,
                              logic [31:0] m1a, logic [31:0] m1wd, logic [3:0] m1sel,
                              logic sack, logic [31:0] srd);
    vec_t v;
    v = '{default: '0};
    v.m0r = m0r; v.m0a = m0a; v.m1r = m1r; v.m1we = m1we; v.m1a = m1a;
    v.m1wd = m1wd; v.m1sel = m1sel; v.sack = sack; v.srd = srd;
    return v;
  endfunction

  function automatic vec_t ve(vec_t vin, logic ce, logic we, logic [31:0] addr,
                              logic [31:0] wd, logic [3:0] sel,
                              logic a0, logic e0, logic [31:0] rd0,
                              logic a1, logic e1, logic [31:0] rd1, logic stall);
    vec_t v;
    v = vin;
    v.ce = ce; v.we = we; v.addr = addr; v.wd = wd; v.sel = sel;
    v.a0 = a0; v.e0 = e0; v.rd0 = rd0; v.a1 = a1; v.e1 = e1; v.rd1 = rd1;
    v.stall = stall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_req = v.m0r; m0_addr = v.m0a;
    m1_req = v.m1r; m1_we = v.m1we; m1_addr = v.m1a; m1_wdata = v.m1wd;
    m1_sel = v.m1sel; s_ack = v.sack; s_rdata = v.srd;
  endtask

  task automatic check(input vec_t v, input string nm);
    chk({nm, ".s_ce"},     32'(s_ce),     32'(v.ce));
    chk({nm, ".s_we"},     32'(s_we),     32'(v.we));
    chk({nm, ".s_addr"},   s_addr,        v.addr);
    chk({nm, ".s_wdata"},  s_wdata,       v.wd);
    chk({nm, ".s_sel"},    32'(s_sel),    32'(v.sel));
    chk({nm, ".m0_ack"},   32'(m0_ack),   32'(v.a0));
    chk({nm, ".m0_err"},   32'(m0_err),   32'(v.e0));
    chk({nm, ".m0_rdata"}, m0_rdata,      v.rd0);
    chk({nm, ".m1_ack"},   32'(m1_ack),   32'(v.a1));
    chk({nm, ".m1_err"},   32'(m1_err),   32'(v.e1));
    chk({nm, ".m1_rdata"}, m1_rdata,      v.rd1);
    chk({nm, ".stallreq"}, 32'(stallreq), 32'(v.stall));
  endtask

  // One clock cycle: drive after the falling edge, sample 1 ns later.
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #1;
    check(v, nm);
  endtask

  localparam logic [31:0] R0  = 32'h3401_1100;
  localparam logic [31:0] DA  = 32'hAAAA_0001;
  localparam logic [31:0] DB  = 32'hBBBB_0002;
  localparam logic [31:0] DC  = 32'hCCCC_0003;
  localparam logic [31:0] BEF = 32'hDEAD_BEEF;
  localparam logic [31:0] WD  = 32'h1234_5678;

  vec_t tbl[$];
  vec_t v;

  initial begin
    // ---- reset state, with both requests high: stallreq must stay 0 ----
    rst = 1'b0;
    drive(vi(1, 32'h10, 1, 1, 32'h20, BEF, 4'h3, 1, 32'h99));
    #12;
    check(ve(vi(0,0,0,0,0,0,0,0,0), 0,0,0,0,0, 0,0,0, 0,0,0, 0), "reset");
    @(negedge clk);
    drive(vi(0,0,0,0,0,0,0,0,0));
    rst = 1'b1;

    // ---- single fetch, write with 3 wait states, contention, stray ack ----
    tbl.push_back(ve(vi(1,32'h10,0,0,0,0,0,0,0),            0,0,0,0,0,          0,0,0,  0,0,0, 1));
    tbl.push_back(ve(vi(1,32'h10,0,0,0,0,0,1,R0),           1,0,32'h10,0,4'hF,  0,0,0,  0,0,0, 1));
    tbl.push_back(ve(vi(1,32'h10,0,0,0,0,0,0,0),            0,0,0,0,0,          1,0,R0, 0,0,0, 0));
    tbl.push_back(ve(vi(0,0,0,0,0,0,0,0,0),                 0,0,0,0,0,          0,0,R0, 0,0,0, 0));
    tbl.push_back(ve(vi(0,0,1,1,32'h8,BEF,4'h3,0,0),        0,0,0,0,0,          0,0,R0, 0,0,0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(ve(vi(0,0,1,1,32'h8,BEF,4'h3,0,0),      1,1,32'h8,BEF,4'h3, 0,0,R0, 0,0,0, 1));
    tbl.push_back(ve(vi(0,0,1,1,32'h8,BEF,4'h3,1,0),        1,1,32'h8,BEF,4'h3, 0,0,R0, 0,0,0, 1));
    tbl.push_back(ve(vi(0,0,1,1,32'h8,BEF,4'h3,0,0),        0,0,0,0,0,          0,0,R0, 1,0,0, 0));
    tbl.push_back(ve(vi(0,0,0,0,0,0,0,0,0),                 0,0,0,0,0,          0,0,R0, 0,0,0, 0));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,0,0), 0,0,0,0,0,          0,0,R0, 0,0,0, 1));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,1,DA),1,0,32'h100,0,4'hF, 0,0,R0, 0,0,0, 1));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,0,0), 0,0,0,0,0,          1,0,DA, 0,0,0, 1));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,0,0), 0,0,0,0,0,          0,0,DA, 0,0,0, 1));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,1,DB),1,0,32'h200,WD,4'hF,0,0,DA, 0,0,0, 1));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,0,0), 0,0,0,0,0,          0,0,DA, 1,0,DB,1));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,0,0), 0,0,0,0,0,          0,0,DA, 0,0,DB,1));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,1,DC),1,0,32'h100,0,4'hF, 0,0,DA, 0,0,DB,1));
    tbl.push_back(ve(vi(1,32'h100,1,0,32'h200,WD,4'hF,0,0), 0,0,0,0,0,          1,0,DC, 0,0,DB,1));
    tbl.push_back(ve(vi(0,0,0,0,0,0,0,1,32'hDEAD_DEAD),     0,0,0,0,0,          0,0,DC, 0,0,DB,0));
    tbl.push_back(ve(vi(0,0,0,0,0,0,0,0,0),                 0,0,0,0,0,          0,0,DC, 0,0,DB,0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // ---- timeout: m1 read, slave silent for 15 GNT cycles ----
    apply(ve(vi(0,0,1,0,32'h40,0,4'hF,0,0), 0,0,0,0,0, 0,0,DC, 0,0,DB, 1), "to.req");
    for (int k = 1; k <= 15; k++)
      apply(ve(vi(0,0,1,0,32'h40,0,4'hF,0,0), 1,0,32'h40,0,4'hF, 0,0,DC, 0,0,DB, 1),
            $sformatf("to.gnt%0d", k));
    apply(ve(vi(0,0,1,0,32'h40,0,4'hF,0,0), 0,0,0,0,0, 0,0,DC, 1,1,0, 0), "to.resp");
    apply(ve(vi(0,0,0,0,0,0,0,0,0), 0,0,0,0,0, 0,0,DC, 0,0,0, 0), "to.idle");

    // ---- ack arriving in the last allowed wait cycle wins over timeout ----
    apply(ve(vi(1,32'h80,0,0,0,0,0,0,0), 0,0,0,0,0, 0,0,DC, 0,0,0, 1), "col.req");
    for (int k = 1; k <= 15; k++) begin
      v = vi(1,32'h80,0,0,0,0,0, (k == 15), (k == 15) ? 32'h5A5A_5A5A : 32'h0);
      apply(ve(v, 1,0,32'h80,0,4'hF, 0,0,DC, 0,0,0, 1), $sformatf("col.gnt%0d", k));
    end
    apply(ve(vi(1,32'h80,0,0,0,0,0,0,0), 0,0,0,0,0, 1,0,32'h5A5A_5A5A, 0,0,0, 0), "col.resp");
    apply(ve(vi(0,0,0,0,0,0,0,0,0), 0,0,0,0,0, 0,0,32'h5A5A_5A5A, 0,0,0, 0), "col.idle");

    // ---- reset during GNT0: strobe drops at once, no ack, tie goes to m0 ----
    v = vi(1,32'h90,0,0,0,0,0,0,0);
    apply(ve(v, 0,0,0,0,0, 0,0,32'h5A5A_5A5A, 0,0,0, 1), "rst.req");
    apply(ve(v, 1,0,32'h90,0,4'hF, 0,0,32'h5A5A_5A5A, 0,0,0, 1), "rst.gnt");
    #1 rst = 1'b0;
    #1;
    check(ve(v, 0,0,0,0,0, 0,0,0, 0,0,0, 0), "rst.async");
    for (int k = 0; k < 2; k++)
      apply(ve(v, 0,0,0,0,0, 0,0,0, 0,0,0, 0), $sformatf("rst.hold%0d", k));
    @(negedge clk);
    rst = 1'b1;
    v = vi(1,32'h90,1,0,32'hA0,0,4'hF,0,0);
    drive(v);
    #1;
    check(ve(v, 0,0,0,0,0, 0,0,0, 0,0,0, 1), "rst.rel");
    v = vi(1,32'h90,1,0,32'hA0,0,4'hF,1,32'h77);
    apply(ve(v, 1,0,32'h90,0,4'hF, 0,0,0, 0,0,0, 1), "rst.tie");
    v = vi(1,32'h90,1,0,32'hA0,0,4'hF,0,0);
    apply(ve(v, 0,0,0,0,0, 1,0,32'h77, 0,0,0, 1), "rst.resp");
    apply(ve(vi(0,0,0,0,0,0,0,0,0), 0,0,0,0,0, 0,0,32'h77, 0,0,0, 0), "rst.idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
